// File: rtl/ofc_filter.sv
// Optimal-filter reconstruction: pedestal-subtracted 5-tap energy/time MACs followed by
// a fixed-latency 16-step restoring divider producing Q8.8 timing.
module ofc_filter #(
  parameter int unsigned        FRAC = 12,
  parameter logic signed [15:0] A1   = 16'sd512,
  parameter logic signed [15:0] A2   = 16'sd1024,
  parameter logic signed [15:0] A3   = 16'sd1536,
  parameter logic signed [15:0] A4   = 16'sd1024,
  parameter logic signed [15:0] A5   = 16'sd0,
  parameter logic signed [15:0] B1   = -16'sd1024,
  parameter logic signed [15:0] B2   = -16'sd512,
  parameter logic signed [15:0] B3   = 16'sd0,
  parameter logic signed [15:0] B4   = 16'sd512,
  parameter logic signed [15:0] B5   = 16'sd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] ofc_data,
  input  logic [2:0]  ofc_sample_num,
  input  logic [13:0] pedestal,
  output logic [23:0] energy,
  output logic [15:0] tau,
  output logic        valid,
  output logic        div_err,
  output logic        seq_err,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StAccum, StSetup, StDivide, StDone} state_e;

  state_e             state_q;
  logic [2:0]         exp_num_q;
  logic [13:0]        ped_q;
  logic signed [33:0] acc_a_q, acc_b_q;
  logic [23:0]        energy_calc_q;
  logic               neg_q, sat_q, zero_q;
  logic [33:0]        div_r_q, div_d_q;
  logic [15:0]        div_dq_q;
  logic [3:0]         div_cnt_q;

  logic [13:0]        ped_sel;
  logic signed [14:0] x;
  logic signed [15:0] coef_a, coef_b;
  logic signed [30:0] prod_a, prod_b;

  // Sample 1 uses the live pedestal; later samples use the value latched with it.
  assign ped_sel = (state_q == StIdle) ? pedestal : ped_q;
  assign x       = $signed({1'b0, ofc_data}) - $signed({1'b0, ped_sel});

  always_comb begin
    coef_a = '0;
    coef_b = '0;
    case (ofc_sample_num)
      3'd1: begin coef_a = A1; coef_b = B1; end
      3'd2: begin coef_a = A2; coef_b = B2; end
      3'd3: begin coef_a = A3; coef_b = B3; end
      3'd4: begin coef_a = A4; coef_b = B4; end
      3'd5: begin coef_a = A5; coef_b = B5; end
      default: ;
    endcase
  end

  assign prod_a = 31'(x) * 31'(coef_a);
  assign prod_b = 31'(x) * 31'(coef_b);

  logic signed [33:0] energy_sh;
  logic [23:0]        energy_sat;
  logic [33:0]        abs_a, abs_b;
  logic               sat_cond;

  assign energy_sh = acc_a_q >>> FRAC;
  assign abs_a     = acc_a_q[33] ? -acc_a_q : acc_a_q;
  assign abs_b     = acc_b_q[33] ? -acc_b_q : acc_b_q;
  assign sat_cond  = {8'b0, abs_b} >= {abs_a, 8'b0};

  always_comb begin
    if (energy_sh > 34'sd8388607)       energy_sat = 24'h7fffff;
    else if (energy_sh < -34'sd8388608) energy_sat = 24'h800000;
    else                                energy_sat = energy_sh[23:0];
  end

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  logic [34:0] rem_sh;
  logic        q_bit;
  logic [33:0] rem_next;

  assign rem_sh   = {div_r_q, div_dq_q[15]};
  assign q_bit    = rem_sh >= {1'b0, div_d_q};
  assign rem_next = q_bit ? 34'(rem_sh - {1'b0, div_d_q}) : rem_sh[33:0];

  logic [15:0] q_clip;
  assign q_clip = (sat_q || div_dq_q[15]) ? 16'h7fff : div_dq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      exp_num_q     <= '0;
      ped_q         <= '0;
      acc_a_q       <= '0;
      acc_b_q       <= '0;
      energy_calc_q <= '0;
      neg_q         <= 1'b0;
      sat_q         <= 1'b0;
      zero_q        <= 1'b0;
      div_r_q       <= '0;
      div_d_q       <= '0;
      div_dq_q      <= '0;
      div_cnt_q     <= '0;
      energy        <= '0;
      tau           <= '0;
      valid         <= 1'b0;
      div_err       <= 1'b0;
      seq_err       <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      valid   <= 1'b0;
      seq_err <= 1'b0;
      overrun <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ofc_sample_num == 3'd1) begin
            ped_q     <= pedestal;
            acc_a_q   <= 34'(prod_a);
            acc_b_q   <= 34'(prod_b);
            exp_num_q <= 3'd2;
            busy      <= 1'b1;
            state_q   <= StAccum;
          end
        end
        StAccum: begin
          if (ofc_sample_num == exp_num_q) begin
            acc_a_q   <= acc_a_q + 34'(prod_a);
            acc_b_q   <= acc_b_q + 34'(prod_b);
            exp_num_q <= exp_num_q + 3'd1;
            if (exp_num_q == 3'd5) state_q <= StSetup;
          end else begin
            seq_err <= 1'b1;
            acc_a_q <= '0;
            acc_b_q <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StSetup: begin
          energy_calc_q <= energy_sat;
          neg_q         <= acc_a_q[33] ^ acc_b_q[33];
          zero_q        <= (acc_a_q == '0);
          sat_q         <= (acc_a_q != '0) && sat_cond;
          div_cnt_q     <= '0;
          if ((acc_a_q == '0) || sat_cond) begin
            div_r_q  <= '0;
            div_d_q  <= '0;
            div_dq_q <= '0;
          end else begin
            div_r_q  <= {8'b0, abs_b[33:8]};
            div_d_q  <= abs_a;
            div_dq_q <= {abs_b[7:0], 8'b0};
          end
          state_q <= StDivide;
        end
        StDivide: begin
          div_r_q   <= rem_next;
          div_dq_q  <= {div_dq_q[14:0], q_bit};
          div_cnt_q <= div_cnt_q + 4'd1;
          if (div_cnt_q == 4'd15) state_q <= StDone;
        end
        StDone: begin
          energy  <= energy_calc_q;
          tau     <= zero_q ? 16'h0000 : (neg_q ? -q_clip : q_clip);
          div_err <= zero_q;
          valid   <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
      if ((state_q == StSetup || state_q == StDivide || state_q == StDone) &&
          ofc_sample_num == 3'd1) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
